// File: rtl/network_pkg.sv
// Shared network datapath definitions.
//   CHANNELS / TAPS : vector width and number of conv1d input taps
//   sample_t        : default signed fixed-point sample
//   chan_vec_t      : one CHANNELS-wide result vector
//   state_t         : capture/strobe sequencing state
package network_pkg;

  localparam int CHANNELS = 8;
  localparam int TAPS     = 4;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [CHANNELS-1:0]     chan_vec_t;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle pulse on a low-to-high transition of a level signal.
//   clk   : system clock
//   rst   : asynchronous active-low reset (previous level cleared)
//   level : sampled level input
//   pulse : high while level=1 and the previous-cycle level was 0
// A level already high when reset releases yields one pulse.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/activation_history_buffer.sv
// History of conv0 result vectors presented as 4 dilated taps to conv1.
//   clk, rst            : clock, asynchronous active-low reset
//   in_v                : upstream valid level; one capture per rising edge
//   in_d0..in_d7        : upstream channel samples
//   flush               : synchronous clear of history; beats a capture
//   out_aK_dC           : tap K (a3 newest), channel C, registered history
//   out_stb             : one-cycle pulse in the cycle after each capture
//   primed              : history completely filled (DEPTH captures)
//   fill_count          : captures held, saturating at DEPTH
module activation_history_buffer
  import network_pkg::*;
#(
  parameter int W        = 16,
  parameter int DILATION = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_v,
  input  logic signed [W-1:0] in_d0, in_d1, in_d2, in_d3,
  input  logic signed [W-1:0] in_d4, in_d5, in_d6, in_d7,
  input  logic                flush,
  output logic signed [W-1:0] out_a0_d0, out_a0_d1, out_a0_d2, out_a0_d3,
  output logic signed [W-1:0] out_a0_d4, out_a0_d5, out_a0_d6, out_a0_d7,
  output logic signed [W-1:0] out_a1_d0, out_a1_d1, out_a1_d2, out_a1_d3,
  output logic signed [W-1:0] out_a1_d4, out_a1_d5, out_a1_d6, out_a1_d7,
  output logic signed [W-1:0] out_a2_d0, out_a2_d1, out_a2_d2, out_a2_d3,
  output logic signed [W-1:0] out_a2_d4, out_a2_d5, out_a2_d6, out_a2_d7,
  output logic signed [W-1:0] out_a3_d0, out_a3_d1, out_a3_d2, out_a3_d3,
  output logic signed [W-1:0] out_a3_d4, out_a3_d5, out_a3_d6, out_a3_d7,
  output logic                out_stb,
  output logic                primed,
  output logic [4:0]          fill_count
);

  localparam int         DEPTH     = 3 * DILATION + 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  logic signed [W-1:0] in_vec [CHANNELS];
  logic signed [W-1:0] hist   [DEPTH][CHANNELS];
  logic signed [W-1:0] tap    [TAPS][CHANNELS];
  logic                rise;
  logic                capture;
  logic [4:0]          fill_next;
  state_t              state, state_next;

  assign in_vec = '{in_d0, in_d1, in_d2, in_d3, in_d4, in_d5, in_d6, in_d7};

  rising_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (in_v),
    .pulse (rise)
  );

  // The edge detector keeps tracking in_v during flush, so a held level
  // cannot produce a late capture once flush drops.
  assign capture = rise & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '{default: '0};
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '{default: '0};
    end else if (capture) begin
      hist[0] <= in_vec;
      for (int unsigned i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign fill_next = (fill_count == DEPTH_CNT) ? fill_count : fill_count + 5'd1;

  // primed is registered from the post-capture count so it rises on the same
  // edge as the capture that fills the history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count <= '0;
      primed     <= 1'b0;
    end else if (flush) begin
      fill_count <= '0;
      primed     <= 1'b0;
    end else if (capture) begin
      fill_count <= fill_next;
      primed     <= (fill_next == DEPTH_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    out_stb    = 1'b0;
    case (state)
      IDLE:    if (capture) state_next = UPDATE;
      UPDATE: begin
        out_stb = 1'b1;
        if (capture) state_next = UPDATE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++)
      tap[k] = hist[(TAPS - 1 - k) * DILATION];
  end

  assign out_a0_d0 = tap[0][0]; assign out_a0_d1 = tap[0][1];
  assign out_a0_d2 = tap[0][2]; assign out_a0_d3 = tap[0][3];
  assign out_a0_d4 = tap[0][4]; assign out_a0_d5 = tap[0][5];
  assign out_a0_d6 = tap[0][6]; assign out_a0_d7 = tap[0][7];
  assign out_a1_d0 = tap[1][0]; assign out_a1_d1 = tap[1][1];
  assign out_a1_d2 = tap[1][2]; assign out_a1_d3 = tap[1][3];
  assign out_a1_d4 = tap[1][4]; assign out_a1_d5 = tap[1][5];
  assign out_a1_d6 = tap[1][6]; assign out_a1_d7 = tap[1][7];
  assign out_a2_d0 = tap[2][0]; assign out_a2_d1 = tap[2][1];
  assign out_a2_d2 = tap[2][2]; assign out_a2_d3 = tap[2][3];
  assign out_a2_d4 = tap[2][4]; assign out_a2_d5 = tap[2][5];
  assign out_a2_d6 = tap[2][6]; assign out_a2_d7 = tap[2][7];
  assign out_a3_d0 = tap[3][0]; assign out_a3_d1 = tap[3][1];
  assign out_a3_d2 = tap[3][2]; assign out_a3_d3 = tap[3][3];
  assign out_a3_d4 = tap[3][4]; assign out_a3_d5 = tap[3][5];
  assign out_a3_d6 = tap[3][6]; assign out_a3_d7 = tap[3][7];

endmodule
